// File: rtl/operand_issue.sv
// Issue stage ahead of the ALU: operand read with writeback forwarding, load
// scoreboard and outstanding-load limit, registered valid/ready output bundle.
module operand_issue #(
  parameter int NUM_REGS           = 32,
  parameter int REG_AW             = 5,
  parameter int MAX_LOADS          = 4,
  parameter int ZERO_REG_HARDWIRED = 1,
  localparam int LCW               = $clog2(MAX_LOADS + 1)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic              writes_rd_i,
  input  logic              is_load_i,
  output logic [REG_AW-1:0] rf_rd_addr_o,
  output logic [REG_AW-1:0] rf_rs_addr_o,
  input  logic [31:0]       rf_rd_data_i,
  input  logic [31:0]       rf_rs_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic              wb_is_load_i,
  input  logic              flush_i,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output logic [31:0]       alu_instr_o,
  output logic [31:0]       alu_rd_o,
  output logic [31:0]       alu_rs_o,
  output logic [REG_AW-1:0] alu_dst_o,
  output logic              alu_writes_rd_o,
  output logic [LCW-1:0]    loads_pending_o
);

  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rd_op_q, rd_op_d;
  logic [31:0]         rs_op_q, rs_op_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic                wr_q, wr_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [LCW-1:0]      loads_q, loads_d;

  logic rd_is_zero, rs_is_zero;
  logic [31:0] rd_op, rs_op;
  logic wb_ld_clr, rd_busy, rs_busy, waw, load_full, hazard;
  logic ready, accept, ld_inc, ld_dec;

  assign rf_rd_addr_o = rd_addr_i;
  assign rf_rs_addr_o = rs_addr_i;

  assign rd_is_zero = (ZERO_REG_HARDWIRED != 0) && (rd_addr_i == '0);
  assign rs_is_zero = (ZERO_REG_HARDWIRED != 0) && (rs_addr_i == '0);

  assign rd_op = rd_is_zero ? 32'd0 :
                 (wb_en_i && wb_addr_i == rd_addr_i) ? wb_data_i : rf_rd_data_i;
  assign rs_op = rs_is_zero ? 32'd0 :
                 (wb_en_i && wb_addr_i == rs_addr_i) ? wb_data_i : rf_rs_data_i;

  // A load writeback in this cycle releases its register immediately.
  assign wb_ld_clr = wb_en_i && wb_is_load_i;
  assign rd_busy   = sb_q[rd_addr_i] && !(wb_ld_clr && wb_addr_i == rd_addr_i);
  assign rs_busy   = sb_q[rs_addr_i] && !(wb_ld_clr && wb_addr_i == rs_addr_i);
  assign waw       = writes_rd_i && rd_busy;
  assign load_full = is_load_i && (loads_q == LCW'(MAX_LOADS)) && !wb_ld_clr;
  assign hazard    = rd_busy || rs_busy || waw || load_full;

  assign ready  = !reset_i && !flush_i && !hazard && (!valid_q || alu_ready_i);
  assign accept = instr_valid_i && ready;
  assign ld_inc = accept && is_load_i;
  assign ld_dec = wb_ld_clr && (loads_q != '0);

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    rd_op_d = rd_op_q;
    rs_op_d = rs_op_q;
    dst_d   = dst_q;
    wr_d    = wr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      rd_op_d = rd_op;
      rs_op_d = rs_op;
      dst_d   = rd_addr_i;
      wr_d    = writes_rd_i;
    end else if (alu_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Set after clear so a same-cycle reissue to the same register stays pending.
  always_comb begin
    sb_d = sb_q;
    if (wb_ld_clr) sb_d[wb_addr_i] = 1'b0;
    if (accept && is_load_i && writes_rd_i && !rd_is_zero) sb_d[rd_addr_i] = 1'b1;
  end

  always_comb begin
    loads_d = loads_q;
    if (ld_inc && !ld_dec)      loads_d = loads_q + 1'b1;
    else if (!ld_inc && ld_dec) loads_d = loads_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      rd_op_q <= '0;
      rs_op_q <= '0;
      dst_q   <= '0;
      wr_q    <= 1'b0;
      sb_q    <= '0;
      loads_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      rd_op_q <= rd_op_d;
      rs_op_q <= rs_op_d;
      dst_q   <= dst_d;
      wr_q    <= wr_d;
      sb_q    <= sb_d;
      loads_q <= loads_d;
    end
  end

  assign instr_ready_o   = ready;
  assign alu_valid_o     = valid_q;
  assign alu_instr_o     = instr_q;
  assign alu_rd_o        = rd_op_q;
  assign alu_rs_o        = rs_op_q;
  assign alu_dst_o       = dst_q;
  assign alu_writes_rd_o = wr_q;
  assign loads_pending_o = loads_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: forwarding, load hazards, load limit,
// backpressure, flush and asynchronous reset.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [4:0]  rd_addr_i, rs_addr_i;
  logic        writes_rd_i, is_load_i;
  logic [4:0]  rf_rd_addr_o, rf_rs_addr_o;
  logic [31:0] rf_rd_data_i, rf_rs_data_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_is_load_i;
  logic        flush_i;
  logic        alu_valid_o, alu_ready_i;
  logic [31:0] alu_instr_o, alu_rd_o, alu_rs_o;
  logic [4:0]  alu_dst_o;
  logic        alu_writes_rd_o;
  logic [2:0]  loads_pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  operand_issue dut (
    .clk(clk), .reset_i(reset_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .rd_addr_i(rd_addr_i), .rs_addr_i(rs_addr_i),
    .writes_rd_i(writes_rd_i), .is_load_i(is_load_i),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rs_addr_o(rf_rs_addr_o),
    .rf_rd_data_i(rf_rd_data_i), .rf_rs_data_i(rf_rs_data_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_is_load_i(wb_is_load_i), .flush_i(flush_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_instr_o(alu_instr_o), .alu_rd_o(alu_rd_o), .alu_rs_o(alu_rs_o),
    .alu_dst_o(alu_dst_o), .alu_writes_rd_o(alu_writes_rd_o),
    .loads_pending_o(loads_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [4:0] rd,
                       input logic [4:0] rs, input logic wr, input logic ld,
                       input logic [31:0] rfa, input logic [31:0] rfb);
    instr_valid_i = v;  instr_i = ins;  rd_addr_i = rd;  rs_addr_i = rs;
    writes_rd_i = wr;   is_load_i = ld; rf_rd_data_i = rfa; rf_rs_data_i = rfb;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d, input logic ld);
    wb_en_i = en; wb_addr_i = a; wb_data_i = d; wb_is_load_i = ld;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; alu_ready_i = 1'b1;
    offer(1'b1, 32'h1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd1, 32'd2);
    wb(1'b0, 5'd0, 32'd0, 1'b0);
    step(); step();
    check_eq("rst_valid", alu_valid_o, 0);
    check_eq("rst_ready", instr_ready_o, 0);
    check_eq("rst_rd", alu_rd_o, 0);
    check_eq("rst_dst", alu_dst_o, 0);
    check_eq("rst_loads", loads_pending_o, 0);
    reset_i = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();

    // ADDU rd=3 rs=4
    offer(1'b1, 32'h0000_1111, 5'd3, 5'd4, 1'b1, 1'b0, 32'd10, 32'd5);
    #1;
    check_eq("addu_ready", instr_ready_o, 1);
    check_eq("rf_addr_a", rf_rd_addr_o, 3);
    check_eq("rf_addr_b", rf_rs_addr_o, 4);
    step();
    check_eq("addu_valid", alu_valid_o, 1);
    check_eq("addu_instr", alu_instr_o, 32'h0000_1111);
    check_eq("addu_rd", alu_rd_o, 10);
    check_eq("addu_rs", alu_rs_o, 5);
    check_eq("addu_dst", alu_dst_o, 3);
    check_eq("addu_wr", alu_writes_rd_o, 1);

    // Forwarding on rs, rd=0 reads zero
    offer(1'b1, 32'h2, 5'd0, 5'd4, 1'b1, 1'b0, 32'd99, 32'd5);
    wb(1'b1, 5'd4, 32'h0000_DEAD, 1'b0);
    step();
    check_eq("fwd_rs", alu_rs_o, 32'h0000_DEAD);
    check_eq("fwd_rd_zero", alu_rd_o, 0);
    // Forwarding on rd
    offer(1'b1, 32'h3, 5'd6, 5'd9, 1'b0, 1'b0, 32'd7, 32'd8);
    wb(1'b1, 5'd6, 32'h0000_1234, 1'b0);
    step();
    check_eq("fwd_rd", alu_rd_o, 32'h0000_1234);
    check_eq("fwd_rs_rf", alu_rs_o, 8);
    check_eq("nofwd_wr", alu_writes_rd_o, 0);
    // Writeback to r0 must not forward
    offer(1'b1, 32'h4, 5'd0, 5'd0, 1'b1, 1'b0, 32'd7, 32'd8);
    wb(1'b1, 5'd0, 32'h77, 1'b0);
    step();
    check_eq("r0_nofwd_a", alu_rd_o, 0);
    check_eq("r0_nofwd_b", alu_rs_o, 0);
    wb(1'b0, 5'd0, 32'd0, 1'b0);

    // LW r7 then dependent ADDU
    offer(1'b1, 32'h5, 5'd7, 5'd2, 1'b1, 1'b1, 32'd0, 32'd0);
    step();
    check_eq("lw_loads", loads_pending_o, 1);
    offer(1'b1, 32'h6, 5'd7, 5'd1, 1'b1, 1'b0, 32'd0, 32'd3);
    #1;
    check_eq("raw_stall", instr_ready_o, 0);
    step();
    check_eq("raw_nobundle", alu_valid_o, 0);
    check_eq("raw_stall2", instr_ready_o, 0);
    wb(1'b1, 5'd7, 32'h55, 1'b1);
    #1;
    check_eq("raw_release", instr_ready_o, 1);
    step();
    check_eq("raw_valid", alu_valid_o, 1);
    check_eq("raw_rd", alu_rd_o, 32'h55);
    check_eq("raw_loads", loads_pending_o, 0);
    wb(1'b0, 5'd0, 32'd0, 1'b0);

    // Load writeback at zero count is ignored
    offer(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wb(1'b1, 5'd20, 32'd1, 1'b1);
    step();
    check_eq("underflow", loads_pending_o, 0);
    wb(1'b0, 5'd0, 32'd0, 1'b0);

    // Four loads fill the limit
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 32'h100 + i, 5'(i), 5'd0, 1'b1, 1'b1, 32'd0, 32'd0);
      step();
    end
    check_eq("full_loads", loads_pending_o, 4);
    offer(1'b1, 32'h105, 5'd5, 5'd0, 1'b1, 1'b1, 32'd0, 32'd0);
    #1;
    check_eq("full_stall", instr_ready_o, 0);
    step();
    check_eq("full_hold", loads_pending_o, 4);
    wb(1'b1, 5'd1, 32'd11, 1'b1);
    #1;
    check_eq("full_release", instr_ready_o, 1);
    step();
    check_eq("full_swap", loads_pending_o, 4);
    check_eq("full_dst", alu_dst_o, 5);
    offer(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      wb(1'b1, 5'(i), 32'd0, 1'b1);
      step();
    end
    wb(1'b0, 5'd0, 32'd0, 1'b0);
    check_eq("drain_loads", loads_pending_o, 0);

    // Backpressure
    alu_ready_i = 1'b0;
    offer(1'b1, 32'h0A, 5'd8, 5'd9, 1'b1, 1'b0, 32'd1, 32'd2);
    step();
    offer(1'b1, 32'h0B, 5'd8, 5'd9, 1'b1, 1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_ready", instr_ready_o, 0);
      step();
      check_eq("bp_valid", alu_valid_o, 1);
      check_eq("bp_instr", alu_instr_o, 32'h0A);
      check_eq("bp_rd", alu_rd_o, 1);
    end
    alu_ready_i = 1'b1;
    #1;
    check_eq("bp_ready_rel", instr_ready_o, 1);
    step();
    check_eq("bb_instr_b", alu_instr_o, 32'h0B);
    check_eq("bb_rs_b", alu_rs_o, 4);
    offer(1'b1, 32'h0C, 5'd8, 5'd9, 1'b1, 1'b0, 32'd5, 32'd6);
    step();
    check_eq("bb_instr_c", alu_instr_o, 32'h0C);
    check_eq("bb_valid_c", alu_valid_o, 1);
    offer(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_eq("drain_valid", alu_valid_o, 0);

    // Flush with a pending load
    offer(1'b1, 32'h0D, 5'd10, 5'd0, 1'b1, 1'b1, 32'd0, 32'd0);
    step();
    check_eq("fl_pre_valid", alu_valid_o, 1);
    offer(1'b1, 32'h0E, 5'd11, 5'd0, 1'b1, 1'b0, 32'd1, 32'd1);
    flush_i = 1'b1;
    #1;
    check_eq("fl_ready", instr_ready_o, 0);
    step();
    flush_i = 1'b0;
    check_eq("fl_valid", alu_valid_o, 0);
    check_eq("fl_loads", loads_pending_o, 1);
    offer(1'b1, 32'h0F, 5'd10, 5'd0, 1'b1, 1'b0, 32'd1, 32'd1);
    #1;
    check_eq("fl_sb_kept", instr_ready_o, 0);
    step();
    offer(1'b1, 32'h10, 5'd12, 5'd0, 1'b1, 1'b0, 32'd9, 32'd1);
    step();
    check_eq("post_fl_valid", alu_valid_o, 1);
    check_eq("post_fl_rd", alu_rd_o, 9);

    // Asynchronous reset mid-stream
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("mid_rst_valid", alu_valid_o, 0);
    check_eq("mid_rst_rd", alu_rd_o, 0);
    check_eq("mid_rst_instr", alu_instr_o, 0);
    check_eq("mid_rst_loads", loads_pending_o, 0);
    check_eq("mid_rst_ready", instr_ready_o, 0);
    step();
    reset_i = 1'b0;
    offer(1'b1, 32'h11, 5'd10, 5'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    #1;
    check_eq("rst_sb_clear", instr_ready_o, 1);
    step();
    check_eq("rst_after_rd", alu_rd_o, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
